// File: rtl/store_unit_pkg.sv
// Shared definitions for the store path: FSM state encoding, size masks
// and small lane/byte helpers used by the aligner and the control FSM.
package store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        FAULT = 2'd3
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Size mask for the request; a byte store wins over a halfword store.
    function automatic logic [3:0] size_mask(input logic sb, input logic sh);
        logic [3:0] m;
        if (sb) begin
            m = BE_BYTE;
        end else if (sh) begin
            m = BE_HALF;
        end else begin
            m = BE_WORD;
        end
        return m;
    endfunction

    // Expand a 4-bit byte-enable into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and data-memory write-port bundle of the store unit.
// slave: the store unit itself. master: the requester plus memory side.
interface store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        sb;
    logic        sh;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        misaligned_fault;

    modport slave (
        input  req_valid, addr, data_in, sb, sh, mem_ack,
        output req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be,
               done, misaligned_fault
    );

    modport master (
        output req_valid, addr, data_in, sb, sh, mem_ack,
        input  req_ready, mem_wr_en, mem_addr, mem_wdata, mem_be,
               done, misaligned_fault
    );
endinterface

// File: rtl/store_align.sv
// Combinational lane aligner: places the size-masked store data and its
// byte enables into a two-word window starting at the byte offset, and
// reports whether the store spills into the next word and whether it is
// naturally misaligned for its size.
module store_align
    import store_unit_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [1:0]  off,
    input  logic        sb,
    input  logic        sh,
    output logic [63:0] lane_vec,
    output logic [7:0]  be_vec,
    output logic        split,
    output logic        nat_misaligned
);

    logic [3:0]  mask_s;
    logic [31:0] data_m_s;

    // Mask data to size, shift data and enables to the byte offset, classify.
    always_comb begin
        mask_s   = size_mask(sb, sh);
        data_m_s = data_in & byte_mask(mask_s);
        lane_vec = {32'd0, data_m_s} << {off, 3'b000};
        be_vec   = {4'd0, mask_s} << off;
        split    = |be_vec[7:4];
        if (mask_s == BE_WORD) begin
            nat_misaligned = (off != 2'b00);
        end else if (mask_s == BE_HALF) begin
            nat_misaligned = off[0];
        end else begin
            nat_misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one sb/sh/sw request, writes it to a word-addressed
// data memory in one beat, or two beats when it crosses a word boundary,
// and pulses done when retired. With splitting disabled, naturally
// misaligned stores retire immediately with misaligned_fault and no write.
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    store_unit_if.slave bus
);

    logic [63:0] lane_vec_s;
    logic [7:0]  be_vec_s;
    logic        split_s;
    logic        nat_mis_s;

    state_e      state_r,     state_n;
    logic        req_ready_r, req_ready_n;
    logic        wr_en_r,     wr_en_n;
    logic [31:0] addr_r,      addr_n;
    logic [31:0] wdata_r,     wdata_n;
    logic [3:0]  be_r,        be_n;
    logic        done_r,      done_n;
    logic        fault_r,     fault_n;
    logic [31:0] hi_wdata_r,  hi_wdata_n;
    logic [3:0]  hi_be_r,     hi_be_n;
    logic        split_r,     split_n;

    store_align u_align (
        .data_in        (bus.data_in),
        .off            (bus.addr[1:0]),
        .sb             (bus.sb),
        .sh             (bus.sh),
        .lane_vec       (lane_vec_s),
        .be_vec         (be_vec_s),
        .split          (split_s),
        .nat_misaligned (nat_mis_s)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n    = state_r;
        wr_en_n    = wr_en_r;
        addr_n     = addr_r;
        wdata_n    = wdata_r;
        be_n       = be_r;
        done_n     = 1'b0;
        fault_n    = 1'b0;
        hi_wdata_n = hi_wdata_r;
        hi_be_n    = hi_be_r;
        split_n    = split_r;

        case (state_r)
            IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    hi_wdata_n = lane_vec_s[63:32];
                    hi_be_n    = be_vec_s[7:4];
                    split_n    = split_s;
                    if (!SPLIT_MISALIGNED && nat_mis_s) begin
                        state_n = FAULT;
                        wr_en_n = 1'b0;
                        done_n  = 1'b1;
                        fault_n = 1'b1;
                    end else begin
                        state_n = BEAT0;
                        wr_en_n = 1'b1;
                        addr_n  = {bus.addr[31:2], 2'b00};
                        wdata_n = lane_vec_s[31:0];
                        be_n    = be_vec_s[3:0];
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            BEAT0: begin
                if (bus.mem_ack) begin
                    if (split_r) begin
                        state_n = BEAT1;
                        addr_n  = addr_r + 32'd4;
                        wdata_n = hi_wdata_r;
                        be_n    = hi_be_r;
                    end else begin
                        state_n = IDLE;
                        wr_en_n = 1'b0;
                        done_n  = 1'b1;
                    end
                end else begin
                    state_n = BEAT0;
                end
            end
            BEAT1: begin
                if (bus.mem_ack) begin
                    state_n = IDLE;
                    wr_en_n = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    state_n = BEAT1;
                end
            end
            FAULT: begin
                state_n = IDLE;
                wr_en_n = 1'b0;
            end
            default: begin
                state_n = IDLE;
                wr_en_n = 1'b0;
            end
        endcase

        req_ready_n = (state_n == IDLE);
    end

    // State and output registers; reset abandons any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            wr_en_r     <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            be_r        <= 4'd0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            hi_wdata_r  <= 32'd0;
            hi_be_r     <= 4'd0;
            split_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            req_ready_r <= req_ready_n;
            wr_en_r     <= wr_en_n;
            addr_r      <= addr_n;
            wdata_r     <= wdata_n;
            be_r        <= be_n;
            done_r      <= done_n;
            fault_r     <= fault_n;
            hi_wdata_r  <= hi_wdata_n;
            hi_be_r     <= hi_be_n;
            split_r     <= split_n;
        end
    end

    assign bus.req_ready        = req_ready_r;
    assign bus.mem_wr_en        = wr_en_r;
    assign bus.mem_addr         = addr_r;
    assign bus.mem_wdata        = wdata_r;
    assign bus.mem_be           = be_r;
    assign bus.done             = done_r;
    assign bus.misaligned_fault = fault_r;

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: two instances (splitting on / off), a requester
// driver, a memory responder with programmable ack delay, and a
// scoreboard fed by a byte-by-byte reference model.
module tb_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_unit_if bus_s ();
    store_unit_if bus_f ();

    store_unit #(.SPLIT_MISALIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
    store_unit #(.SPLIT_MISALIGNED(1'b0)) dut_f (.clk(clk), .rst_n(rst_n), .bus(bus_f));

    // index 0 = splitting instance, index 1 = faulting instance
    logic        rq_valid [2];
    logic [31:0] rq_addr  [2];
    logic [31:0] rq_data  [2];
    logic        rq_sb    [2];
    logic        rq_sh    [2];
    logic        ack_d    [2];
    logic        rdy [2], wr [2], dn [2], flt [2];
    logic [31:0] maddr [2], mwd [2];
    logic [3:0]  mbe [2];

    assign bus_s.req_valid = rq_valid[0];  assign bus_f.req_valid = rq_valid[1];
    assign bus_s.addr      = rq_addr[0];   assign bus_f.addr      = rq_addr[1];
    assign bus_s.data_in   = rq_data[0];   assign bus_f.data_in   = rq_data[1];
    assign bus_s.sb        = rq_sb[0];     assign bus_f.sb        = rq_sb[1];
    assign bus_s.sh        = rq_sh[0];     assign bus_f.sh        = rq_sh[1];
    assign bus_s.mem_ack   = ack_d[0];     assign bus_f.mem_ack   = ack_d[1];
    assign rdy[0] = bus_s.req_ready;       assign rdy[1] = bus_f.req_ready;
    assign wr[0]  = bus_s.mem_wr_en;       assign wr[1]  = bus_f.mem_wr_en;
    assign dn[0]  = bus_s.done;            assign dn[1]  = bus_f.done;
    assign flt[0] = bus_s.misaligned_fault; assign flt[1] = bus_f.misaligned_fault;
    assign maddr[0] = bus_s.mem_addr;      assign maddr[1] = bus_f.mem_addr;
    assign mwd[0]   = bus_s.mem_wdata;     assign mwd[1]   = bus_f.mem_wdata;
    assign mbe[0]   = bus_s.mem_be;        assign mbe[1]   = bus_f.mem_be;

    typedef struct packed {
        logic        g;
        logic        fault;
        logic        zw;
        logic [1:0]  nb;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  be0, be1;
        logic [31:0] acc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0, bad = 0;
    int   cyc = 0;
    int   to_req = 0, to_seen = 0;
    int   beat_idx [2];
    int   wcnt [2];
    bit   in_beat [2];
    bit   ack_eff [2];
    int   wait_mode [2];
    bit   noise_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: walk the store byte by byte, grouping bytes by word address.
    function automatic exp_t model(input logic g, input logic [31:0] a,
                                   input logic [31:0] d, input int n);
        exp_t e;
        logic [31:0] ba, wa;
        int lane;
        e = '0;
        e.g = g;
        if (g == 1'b1 && (int'(a[1:0]) % n) != 0) begin
            e.fault = 1'b1;
            return e;
        end
        for (int k = 0; k < n; k++) begin
            ba = a + 32'(k);
            wa = ba & 32'hFFFF_FFFC;
            lane = int'(ba[1:0]);
            if (k == 0) begin
                e.nb = 2'd1;
                e.a0 = wa;
            end else if (e.nb == 2'd1 && wa != e.a0) begin
                e.nb = 2'd2;
                e.a1 = wa;
            end
            if (e.nb == 2'd1) begin
                e.d0[lane*8 +: 8] = d[k*8 +: 8];
                e.be0[lane] = 1'b1;
            end else begin
                e.d1[lane*8 +: 8] = d[k*8 +: 8];
                e.be1[lane] = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic int pick_wait(input int g);
        if (wait_mode[g] < 0) return int'($urandom_range(0, 2));
        return wait_mode[g];
    endfunction

    function automatic int pending(input int g);
        int c = 0;
        foreach (sbq[i]) if (sbq[i].g == 1'(g)) c++;
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int g);
        int idx;
        exp_t e;
        if (!rst_n) begin
            chk("rst_ready", 32'(rdy[g]), 32'd1);
            chk("rst_wr_en", 32'(wr[g]), 32'd0);
            chk("rst_addr", maddr[g], 32'd0);
            chk("rst_wdata", mwd[g], 32'd0);
            chk("rst_be", 32'(mbe[g]), 32'd0);
            chk("rst_done", 32'(dn[g]), 32'd0);
            chk("rst_fault", 32'(flt[g]), 32'd0);
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i].g == 1'(g)) sbq.delete(i);
            beat_idx[g] = 0;
            in_beat[g] = 1'b0;
            ack_eff[g] = 1'b0;
            ack_d[g] = 1'b0;
        end else begin
            if (ack_eff[g]) begin
                beat_idx[g]++;
                in_beat[g] = 1'b0;
            end
            idx = -1;
            for (int i = 0; i < sbq.size(); i++)
                if (idx < 0 && sbq[i].g == 1'(g)) idx = i;
            if (wr[g]) begin
                if (idx < 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = sbq[idx];
                    if (beat_idx[g] >= int'(e.nb)) begin
                        chk("extra_beat", 32'(beat_idx[g]), 32'(e.nb));
                    end else begin
                        chk("mem_addr",  maddr[g], beat_idx[g] == 0 ? e.a0 : e.a1);
                        chk("mem_wdata", mwd[g],   beat_idx[g] == 0 ? e.d0 : e.d1);
                        chk("mem_be", 32'(mbe[g]), 32'(beat_idx[g] == 0 ? e.be0 : e.be1));
                    end
                    chk("ready_busy", 32'(rdy[g]), 32'd0);
                end
            end
            if (dn[g]) begin
                if (idx < 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sbq[idx];
                    chk("fault_flag", 32'(flt[g]), 32'(e.fault));
                    chk("beat_count", 32'(beat_idx[g]), 32'(e.nb));
                    chk("wr_at_done", 32'(wr[g]), 32'd0);
                    if (e.zw) chk("latency", 32'(cyc) - e.acc, e.fault ? 32'd1 : 32'(e.nb) + 32'd1);
                    sbq.delete(idx);
                end
                beat_idx[g] = 0;
            end else if (flt[g]) begin
                chk("stray_fault", 32'd1, 32'd0);
            end
            if (wr[g]) begin
                if (!in_beat[g]) begin
                    wcnt[g] = pick_wait(g);
                    in_beat[g] = 1'b1;
                end
                if (wcnt[g] == 0) begin
                    ack_d[g] = 1'b1;
                end else begin
                    ack_d[g] = 1'b0;
                    wcnt[g]--;
                end
            end else begin
                ack_d[g] = noise_en && ($urandom_range(0, 3) == 0);
            end
            ack_eff[g] = ack_d[g] && wr[g];
        end
    endtask

    // Scoreboard monitor and memory responder, sampled on the falling edge.
    always @(negedge clk) begin
        if (to_req != to_seen) begin
            chk("timeout", 32'(to_req - to_seen), 32'd0);
            to_seen = to_req;
        end
        for (int g = 0; g < 2; g++) mon(g);
    end

    task automatic issue(input int g, input logic [31:0] a, input logic [31:0] d,
                         input int n, input bit sh_noise);
        exp_t e;
        bit accepted = 1'b0;
        rq_addr[g] = a;
        rq_data[g] = d;
        rq_sb[g] = (n == 1);
        rq_sh[g] = (n == 2) || (n == 1 && sh_noise && $urandom_range(0, 1) == 1);
        rq_valid[g] = 1'b1;
        for (int t = 0; t < 300 && !accepted; t++) begin
            if (rdy[g]) begin
                e = model(1'(g), a, d, n);
                e.zw = (wait_mode[g] == 0) || e.fault;
                e.acc = 32'(cyc);
                sbq.push_back(e);
                accepted = 1'b1;
            end
            @(negedge clk);
        end
        if (!accepted) to_req++;
        rq_valid[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int t = 0;
        while (pending(g) != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (pending(g) != 0) to_req++;
    endtask

    initial begin
        int g, n;
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            rq_valid[i] = 1'b0; rq_addr[i] = 32'd0; rq_data[i] = 32'd0;
            rq_sb[i] = 1'b0; rq_sh[i] = 1'b0; ack_d[i] = 1'b0;
            beat_idx[i] = 0; wcnt[i] = 0; in_beat[i] = 1'b0; ack_eff[i] = 1'b0;
            wait_mode[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);

        // directed, splitting instance, zero-wait memory
        issue(0, 32'h0000_0100, 32'hDEAD_BEEF, 4, 1'b0);
        issue(0, 32'h0000_0203, 32'h1234_56AB, 1, 1'b0);
        issue(0, 32'h0000_0202, 32'hFFFF_CAFE, 2, 1'b0);
        issue(0, 32'h0000_0301, 32'h1122_3344, 4, 1'b0);
        issue(0, 32'h0000_0401, 32'hAAAA_5678, 2, 1'b0);
        wait_idle(0);
        wait_mode[0] = 3;
        issue(0, 32'hFFFF_FFFF, 32'h7777_BEEF, 2, 1'b0);
        wait_idle(0);
        wait_mode[0] = 0;

        // directed, faulting instance
        issue(1, 32'h0000_0041, 32'h0000_1234, 2, 1'b0);
        issue(1, 32'h0000_0100, 32'hDEAD_BEEF, 4, 1'b0);
        issue(1, 32'h0000_0043, 32'h0000_00C3, 1, 1'b0);
        issue(1, 32'h0000_0302, 32'h5555_AAAA, 4, 1'b0);
        issue(1, 32'h0000_0042, 32'h9999_8888, 2, 1'b0);
        wait_idle(1);

        // reset dropped while the second beat waits for its ack
        wait_mode[0] = 40;
        issue(0, 32'h0000_0502, 32'hCAFE_F00D, 4, 1'b0);
        for (int t = 0; t < 200 && !(beat_idx[0] == 1 && wr[0]); t++) @(negedge clk);
        if (!(beat_idx[0] == 1 && wr[0])) to_req++;
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_mode[0] = 0;
        @(negedge clk);
        issue(0, 32'h0000_0600, 32'h0BAD_CAFE, 4, 1'b0);
        wait_idle(0);

        // randomized traffic with random ack delays and stray acks
        wait_mode[0] = -1;
        wait_mode[1] = -1;
        noise_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            g = int'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: n = 1;
                1: n = 2;
                default: n = 4;
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC | {30'd0, a[1:0]};
            issue(g, a, $urandom, n, 1'b1);
        end
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
